// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled counter (edge/center aligned) with
// shadowed settings that are applied only on a cycle boundary.
module pwm_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic [WIDTH-1:0] cnt_nxt,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm
);
    always_ff @(posedge clk_in) begin
        if (rst_in) pwm <= 1'b0;
        else        pwm <= en_in && (cnt_nxt < duty);
    end
endmodule

module pwm_multi #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      en_in,
    input  logic                      update_in,
    input  logic                      mode_in,
    input  logic [PRESCALE_W-1:0]     prescale_in,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      cycle_start_out,
    output logic                      pending_out
);
    typedef struct packed {
        logic                               mode;
        logic [PRESCALE_W-1:0]              prescale;
        logic [WIDTH-1:0]                   period;
        logic [CHANNELS-1:0][WIDTH-1:0]     duty;
    } cfg_t;

    cfg_t                  act, shd, act_nxt, cfg_in;
    logic [WIDTH-1:0]      cnt, cnt_nxt, p_eff;
    logic                  dir, dir_nxt;
    logic [PRESCALE_W-1:0] pre_cnt, pre_nxt;
    logic                  tick, boundary;

    always_comb begin
        cfg_in.mode     = mode_in;
        cfg_in.prescale = prescale_in;
        cfg_in.period   = period_in;
        cfg_in.duty     = duty_in;
    end

    // Center mode treats a zero period as one so the up/down turn still works.
    assign p_eff = (act.period == '0) ? WIDTH'(1) : act.period;
    assign tick  = en_in && (pre_cnt == act.prescale);

    always_comb begin
        pre_nxt  = '0;
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (!en_in) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
        end else begin
            if (!tick) pre_nxt = pre_cnt + 1'b1;
            if (tick) begin
                if (!act.mode) begin
                    dir_nxt = 1'b0;
                    if (cnt >= act.period) begin
                        cnt_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (!dir) begin
                    if (cnt >= p_eff - 1'b1) dir_nxt = 1'b1;
                    else                     cnt_nxt = cnt + 1'b1;
                end else begin
                    // Second tick at zero closes the cycle and turns back up.
                    if (cnt == '0) begin
                        dir_nxt  = 1'b0;
                        boundary = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        act_nxt = act;
        if (!en_in) begin
            if (update_in)        act_nxt = cfg_in;
            else if (pending_out) act_nxt = shd;
        end else if (boundary && pending_out) begin
            act_nxt = shd;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt             <= '0;
            dir             <= 1'b0;
            pre_cnt         <= '0;
            act             <= '0;
            shd             <= '0;
            pending_out     <= 1'b0;
            cycle_start_out <= 1'b0;
        end else begin
            cnt             <= cnt_nxt;
            dir             <= dir_nxt;
            pre_cnt         <= pre_nxt;
            act             <= act_nxt;
            cycle_start_out <= boundary;
            if (update_in) shd <= cfg_in;
            if (update_in && en_in)  pending_out <= 1'b1;
            else if (!en_in)         pending_out <= 1'b0;
            else if (boundary)       pending_out <= 1'b0;
        end
    end

    // Lanes compare against the post-boundary duty so a new setting starts cleanly.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        pwm_lane #(.WIDTH(WIDTH)) u_lane (
            .clk_in  (clk_in),
            .rst_in  (rst_in),
            .en_in   (en_in),
            .cnt_nxt (cnt_nxt),
            .duty    (act_nxt.duty[i]),
            .pwm     (pwm_out[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: edge/center modes, prescaler, shadow updates,
// disable/enable and reset behaviour.
module tb_pwm_multi;
    logic        clk_in = 1'b0;
    logic        rst_in, en_in, update_in, mode_in;
    logic [7:0]  prescale_in, period_in;
    logic [31:0] duty_in;
    logic [3:0]  pwm_out;
    logic        cycle_start_out, pending_out;
    int          checks = 0, errors = 0, n = 0;

    pwm_multi #(.WIDTH(8), .CHANNELS(4), .PRESCALE_W(8)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .en_in           (en_in),
        .update_in       (update_in),
        .mode_in         (mode_in),
        .prescale_in     (prescale_in),
        .period_in       (period_in),
        .duty_in         (duty_in),
        .pwm_out         (pwm_out),
        .cycle_start_out (cycle_start_out),
        .pending_out     (pending_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step;
        @(posedge clk_in);
        #1;
        n++;
    endtask

    task automatic load_cfg(input logic m, input logic [7:0] pre, input logic [7:0] p,
                            input logic [7:0] d3, input logic [7:0] d2,
                            input logic [7:0] d1, input logic [7:0] d0);
        mode_in     = m;
        prescale_in = pre;
        period_in   = p;
        duty_in     = {d3, d2, d1, d0};
        update_in   = 1'b1;
        step;
        update_in   = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) step;
        checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL reset_pwm: got %b exp 0000", pwm_out); end
        checks++; if (cycle_start_out !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b exp 0", cycle_start_out); end
        checks++; if (pending_out !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b exp 0", pending_out); end
        rst_in = 1'b0;
        step;
        checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL reset_idle_pwm: got %b exp 0000", pwm_out); end
    endtask

    task automatic test_edge;
        logic [3:0] exp;
        int c;
        en_in = 1'b0;
        load_cfg(1'b0, 8'd0, 8'd15, 8'd8, 8'd16, 8'd0, 8'd10);
        checks++; if (pending_out !== 1'b0) begin errors++; $display("FAIL edge_direct_load: pending got %b exp 0", pending_out); end
        en_in = 1'b1;
        n = 0;
        repeat (40) begin
            step;
            c = n % 16;
            exp = {c < 8, 1'b1, 1'b0, c < 10};
            checks++; if (pwm_out !== exp) begin errors++; $display("FAIL edge_pwm n=%0d: got %b exp %b", n, pwm_out, exp); end
            checks++; if (cycle_start_out !== (c == 0)) begin errors++; $display("FAIL edge_cs n=%0d: got %b exp %b", n, cycle_start_out, c == 0); end
        end
    endtask

    // Continues from test_edge (n=40, counter at 8).
    task automatic test_update;
        logic [3:0] exp;
        logic       pe;
        int c, d0e;
        while (n < 120) begin
            update_in = (n == 40) || (n == 85) || (n == 95);
            if (n == 40) duty_in[7:0] = 8'd4;
            if (n == 85) duty_in[7:0] = 8'd6;
            if (n == 95) duty_in[7:0] = 8'd12;
            step;
            update_in = 1'b0;
            c   = n % 16;
            d0e = (n < 48) ? 10 : (n < 96) ? 4 : (n < 112) ? 6 : 12;
            pe  = ((n >= 41) && (n < 48)) || ((n >= 86) && (n < 112));
            exp = {c < 8, 1'b1, 1'b0, c < d0e};
            checks++; if (pwm_out !== exp) begin errors++; $display("FAIL update_pwm n=%0d: got %b exp %b", n, pwm_out, exp); end
            checks++; if (pending_out !== pe) begin errors++; $display("FAIL update_pending n=%0d: got %b exp %b", n, pending_out, pe); end
            checks++; if (cycle_start_out !== (c == 0)) begin errors++; $display("FAIL update_cs n=%0d: got %b exp %b", n, cycle_start_out, c == 0); end
        end
    endtask

    task automatic test_disable;
        logic [3:0] exp;
        int c;
        en_in = 1'b0;
        repeat (10) begin
            step;
            checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL disable_pwm: got %b exp 0000", pwm_out); end
            checks++; if (cycle_start_out !== 1'b0) begin errors++; $display("FAIL disable_cs: got %b exp 0", cycle_start_out); end
        end
        en_in = 1'b1;
        n = 0;
        repeat (20) begin
            step;
            c = n % 16;
            exp = {c < 8, 1'b1, 1'b0, c < 12};
            checks++; if (pwm_out !== exp) begin errors++; $display("FAIL reenable_pwm n=%0d: got %b exp %b", n, pwm_out, exp); end
            checks++; if (cycle_start_out !== (c == 0)) begin errors++; $display("FAIL reenable_cs n=%0d: got %b exp %b", n, cycle_start_out, c == 0); end
        end
    endtask

    task automatic test_center;
        int cseq [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
        logic [3:0] exp;
        int k;
        en_in = 1'b0;
        load_cfg(1'b1, 8'd0, 8'd4, 8'd1, 8'd0, 8'd4, 8'd2);
        en_in = 1'b1;
        n = 0;
        repeat (24) begin
            step;
            k = cseq[n % 8];
            exp = {k < 1, 1'b0, 1'b1, k < 2};
            checks++; if (pwm_out !== exp) begin errors++; $display("FAIL center_pwm n=%0d: got %b exp %b", n, pwm_out, exp); end
            checks++; if (cycle_start_out !== (n % 8 == 0)) begin errors++; $display("FAIL center_cs n=%0d: got %b exp %b", n, cycle_start_out, n % 8 == 0); end
        end
        en_in = 1'b0;
        load_cfg(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1);
        en_in = 1'b1;
        n = 0;
        repeat (6) begin
            step;
            checks++; if (pwm_out !== 4'b0001) begin errors++; $display("FAIL center_p0_pwm n=%0d: got %b exp 0001", n, pwm_out); end
            checks++; if (cycle_start_out !== (n % 2 == 0)) begin errors++; $display("FAIL center_p0_cs n=%0d: got %b exp %b", n, cycle_start_out, n % 2 == 0); end
        end
    endtask

    task automatic test_prescale;
        logic [3:0] exp;
        int k;
        en_in = 1'b0;
        load_cfg(1'b0, 8'd3, 8'd3, 8'd0, 8'd0, 8'd0, 8'd2);
        en_in = 1'b1;
        n = 0;
        repeat (36) begin
            step;
            k = (n / 4) % 4;
            exp = {3'b000, k < 2};
            checks++; if (pwm_out !== exp) begin errors++; $display("FAIL prescale_pwm n=%0d: got %b exp %b", n, pwm_out, exp); end
            checks++; if (cycle_start_out !== (n % 16 == 0)) begin errors++; $display("FAIL prescale_cs n=%0d: got %b exp %b", n, cycle_start_out, n % 16 == 0); end
        end
    endtask

    task automatic test_reset_mid;
        en_in = 1'b0;
        load_cfg(1'b0, 8'd0, 8'd15, 8'd8, 8'd16, 8'd0, 8'd10);
        en_in = 1'b1;
        repeat (3) step;
        checks++; if (pwm_out !== 4'b1101) begin errors++; $display("FAIL rstmid_pre_pwm: got %b exp 1101", pwm_out); end
        rst_in = 1'b1;
        step;
        rst_in = 1'b0;
        checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL rstmid_pwm: got %b exp 0000", pwm_out); end
        checks++; if (cycle_start_out !== 1'b0) begin errors++; $display("FAIL rstmid_cs: got %b exp 0", cycle_start_out); end
        checks++; if (pending_out !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b exp 0", pending_out); end
        repeat (10) begin
            step;
            checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL rstmid_hold_pwm: got %b exp 0000", pwm_out); end
        end
        load_cfg(1'b0, 8'd0, 8'd15, 8'd8, 8'd16, 8'd0, 8'd10);
        checks++; if (pending_out !== 1'b1) begin errors++; $display("FAIL rstmid_upd_pending: got %b exp 1", pending_out); end
        checks++; if (pwm_out !== 4'b0) begin errors++; $display("FAIL rstmid_upd_pwm: got %b exp 0000", pwm_out); end
        step;
        checks++; if (pending_out !== 1'b0) begin errors++; $display("FAIL rstmid_apply_pending: got %b exp 0", pending_out); end
        checks++; if (pwm_out !== 4'b1101) begin errors++; $display("FAIL rstmid_apply_pwm: got %b exp 1101", pwm_out); end
        checks++; if (cycle_start_out !== 1'b1) begin errors++; $display("FAIL rstmid_apply_cs: got %b exp 1", cycle_start_out); end
        step;
        checks++; if (pwm_out !== 4'b1101) begin errors++; $display("FAIL rstmid_run_pwm: got %b exp 1101", pwm_out); end
        checks++; if (cycle_start_out !== 1'b0) begin errors++; $display("FAIL rstmid_run_cs: got %b exp 0", cycle_start_out); end
    endtask

    initial begin
        rst_in      = 1'b1;
        en_in       = 1'b0;
        update_in   = 1'b0;
        mode_in     = 1'b0;
        prescale_in = 8'd0;
        period_in   = 8'd0;
        duty_in     = 32'd0;
        test_reset;
        test_edge;
        test_update;
        test_disable;
        test_center;
        test_prescale;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
